// File: rtl/fft_pkg.sv
// Shared types for the radix-2 FFT sequencer: sample format and controller states.
package fft_pkg;

    localparam int FRAC_BITS = 11;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_state_e;

endpackage

// File: rtl/fft_ctrl_addr_gen.sv
// Butterfly address generator: (stage s, butterfly k) -> RAM pair (a, b) and twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int SW    = $clog2(LOG2N) + 1
) (
    input  logic [SW-1:0]    s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-2:0] tw
);

    logic [LOG2N-1:0] kw;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] lo;

    always_comb begin
        kw   = {1'b0, k};
        span = LOG2N'(1) << s;
        lo   = kw & (span - LOG2N'(1));
        // insert a zero at bit s of k: upper bits move up one place, lower bits stay
        a    = ((kw >> s) << (s + SW'(1))) | lo;
        b    = a + span;
        tw   = (LOG2N-1)'(lo << (SW'(LOG2N - 1) - s));
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly read per cycle and replays
// the addresses RD_LAT cycles later as the write-back of the butterfly outputs.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N  = 3,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(LOG2N):0] stage,
    output logic                   rd_en,
    output logic [LOG2N-1:0]       rd_addr_a,
    output logic [LOG2N-1:0]       rd_addr_b,
    output logic [LOG2N-2:0]       tw_addr,
    output logic                   wr_en,
    output logic [LOG2N-1:0]       wr_addr_a,
    output logic [LOG2N-1:0]       wr_addr_b
);

    localparam int SW = $clog2(LOG2N) + 1;
    localparam int AW = LOG2N;
    localparam int KW = LOG2N - 1;

    fft_state_e          state_q, state_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [KW-1:0]       k_q, k_d;
    logic [1:0]          drain_q, drain_d;

    logic                rd_en_q, rd_en_d;
    logic [AW-1:0]       rd_a_q, rd_a_d;
    logic [AW-1:0]       rd_b_q, rd_b_d;
    logic [KW-1:0]       tw_q, tw_d;

    logic [RD_LAT-1:0]           dly_vld_q, dly_vld_d;
    logic [RD_LAT-1:0][AW-1:0]   dly_a_q, dly_a_d;
    logic [RD_LAT-1:0][AW-1:0]   dly_b_q, dly_b_d;

    logic [AW-1:0]       gen_a, gen_b;
    logic [KW-1:0]       gen_tw;

    // Addresses are generated from the next-state counters so the read strobe and
    // its addresses appear together in the first RUN cycle.
    fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_addr_gen (
        .s  (stage_d),
        .k  (k_d),
        .a  (gen_a),
        .b  (gen_b),
        .tw (gen_tw)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (&k_q) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    drain_d = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'(RD_LAT - 1)) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end

        rd_en_d = (state_d == RUN);
        rd_a_d  = rd_en_d ? gen_a  : '0;
        rd_b_d  = rd_en_d ? gen_b  : '0;
        tw_d    = rd_en_d ? gen_tw : '0;
    end

    always_comb begin
        dly_vld_d    = dly_vld_q;
        dly_a_d      = dly_a_q;
        dly_b_d      = dly_b_q;
        dly_vld_d[0] = rd_en_q;
        dly_a_d[0]   = rd_a_q;
        dly_b_d[0]   = rd_b_q;
        for (int i = 1; i < RD_LAT; i++) begin
            dly_vld_d[i] = dly_vld_q[i-1];
            dly_a_d[i]   = dly_a_q[i-1];
            dly_b_d[i]   = dly_b_q[i-1];
        end
        // reads already in flight must never write back after a cancel
        if (abort) begin
            dly_vld_d = '0;
            dly_a_d   = '0;
            dly_b_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            tw_q      <= '0;
            dly_vld_q <= '0;
            dly_a_q   <= '0;
            dly_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            rd_en_q   <= rd_en_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            tw_q      <= tw_d;
            dly_vld_q <= dly_vld_d;
            dly_a_q   <= dly_a_d;
            dly_b_q   <= dly_b_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign wr_en     = dly_vld_q[RD_LAT-1];
    assign wr_addr_a = dly_a_q[RD_LAT-1];
    assign wr_addr_b = dly_b_q[RD_LAT-1];

endmodule
